pe_row_sequencer: RTL and testbench

Sequencer for one Eyeriss processing element's scratchpads. It loads a filter row, streams ifmap words into a circular scratchpad, and issues paired ifmap/filter read addresses with MAC enables for a 1-D sliding-window convolution. Each partial sum is handed off over a valid/ready handshake. The block sits between the GLB-side write ports and the PE datapath (scratchpads plus MAC) and owns every pointer and occupancy count.

---
 rtl/pe_row_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_pe_row_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pe_row_sequencer
// Purpose  : Scratchpad sequencer for one Eyeriss processing element.
//            It loads a filter row, streams ifmap words into a circular
//            scratchpad and issues paired ifmap/filter read addresses with
//            MAC enables for a 1-D sliding-window convolution. Each finished
//            partial sum is handed off over a valid/ready handshake.
// Ports    : clk, rst (sync, active-low)
//            start, cfg_filt_len, cfg_stride, cfg_num_out  - job config
//            filt_wen, filt_ready, filt_waddr, filt_raddr  - filter spad
//            if_wen, if_full, if_waddr, if_raddr, if_count - ifmap spad
//            mac_en, mac_clr                               - MAC control
//            psum_valid, psum_ready                        - psum handoff
//            busy, done, cfg_err                           - status
// Revision : 1.0 - initial release
// ============================================================================
module pe_row_sequencer #(
    parameter int SIZE = 17,
    parameter int AW   = $clog2(SIZE),
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] cfg_filt_len,
    input  logic [AW-1:0] cfg_stride,
    input  logic [CW-1:0] cfg_num_out,
    input  logic          filt_wen,
    output logic          filt_ready,
    output logic [AW-1:0] filt_waddr,
    output logic [AW-1:0] filt_raddr,
    input  logic          if_wen,
    output logic          if_full,
    output logic [AW-1:0] if_waddr,
    output logic [AW-1:0] if_raddr,
    output logic [AW-1:0] if_count,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          psum_valid,
    input  logic          psum_ready,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD_F  = 3'd1;
    localparam logic [2:0] c_ST_WAIT_IF = 3'd2;
    localparam logic [2:0] c_ST_COMPUTE = 3'd3;
    localparam logic [2:0] c_ST_DRAIN   = 3'd4;
    localparam logic [2:0] c_ST_OUT     = 3'd5;
    localparam logic [2:0] c_ST_ADVANCE = 3'd6;
    localparam logic [2:0] c_ST_DONE    = 3'd7;

    localparam logic [AW-1:0] c_ZERO = '0;
    localparam logic [AW-1:0] c_ONE  = AW'(1);
    localparam logic [AW-1:0] c_LAST = AW'(SIZE - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic [AW-1:0] r_filt_len;
    logic [AW-1:0] r_stride;
    logic [CW-1:0] r_num_out;
    logic [AW-1:0] r_filt_wptr;
    logic [AW-1:0] r_k;
    logic [CW-1:0] r_out_cnt;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_if_wptr;
    logic [AW-1:0] r_if_count;
    logic          r_cfg_err;
    logic          w_cfg_ok;
    logic          w_if_full;
    logic          w_if_wr;
    logic [AW-1:0] w_if_count_next;

    // Addition modulo SIZE. Operands are always < SIZE, so a single
    // conditional subtract suffices; SIZE need not be a power of two.
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (AW+1)'(SIZE)) begin
            s = s - (AW+1)'(SIZE);
        end
        return s[AW-1:0];
    endfunction

    assign w_cfg_ok = (cfg_filt_len != c_ZERO) && (cfg_filt_len <= c_LAST) &&
                      (cfg_stride != c_ZERO) && (cfg_stride <= cfg_filt_len) &&
                      (cfg_num_out != '0);

    assign w_if_full = (r_if_count == c_LAST);
    assign w_if_wr   = if_wen && !w_if_full;

    // Occupancy after this cycle: an accepted write and the ADVANCE release
    // may coincide, so both adjustments are folded into one value.
    always_comb begin
        w_if_count_next = r_if_count;
        if (w_if_wr) begin
            w_if_count_next = w_if_count_next + c_ONE;
        end
        if (r_state == c_ST_ADVANCE) begin
            w_if_count_next = w_if_count_next - r_stride;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start && w_cfg_ok) w_state_next = c_ST_LOAD_F;
            end
            c_ST_LOAD_F: begin
                if (filt_wen && (r_filt_wptr == r_filt_len - c_ONE)) begin
                    w_state_next = c_ST_WAIT_IF;
                end
            end
            c_ST_WAIT_IF: begin
                // Next-cycle occupancy so a write landing now is counted.
                if (w_if_count_next >= r_filt_len) w_state_next = c_ST_COMPUTE;
            end
            c_ST_COMPUTE: begin
                if (r_k == r_filt_len - c_ONE) w_state_next = c_ST_DRAIN;
            end
            c_ST_DRAIN:   w_state_next = c_ST_OUT;
            c_ST_OUT: begin
                if (psum_ready) w_state_next = c_ST_ADVANCE;
            end
            c_ST_ADVANCE: begin
                w_state_next = (r_out_cnt == r_num_out) ? c_ST_DONE : c_ST_WAIT_IF;
            end
            c_ST_DONE:    w_state_next = c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_filt_len  <= c_ZERO;
            r_stride    <= c_ZERO;
            r_num_out   <= '0;
            r_filt_wptr <= c_ZERO;
            r_k         <= c_ZERO;
            r_out_cnt   <= '0;
            r_base      <= c_ZERO;
            r_if_wptr   <= c_ZERO;
            r_if_count  <= c_ZERO;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cfg_err  <= (r_state == c_ST_IDLE) && start && !w_cfg_ok;
            r_if_count <= w_if_count_next;
            if (w_if_wr) begin
                r_if_wptr <= mod_add(r_if_wptr, c_ONE);
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (start && w_cfg_ok) begin
                        r_filt_len  <= cfg_filt_len;
                        r_stride    <= cfg_stride;
                        r_num_out   <= cfg_num_out;
                        r_filt_wptr <= c_ZERO;
                        r_k         <= c_ZERO;
                        r_out_cnt   <= '0;
                    end
                end
                c_ST_LOAD_F: begin
                    if (filt_wen) r_filt_wptr <= r_filt_wptr + c_ONE;
                end
                c_ST_COMPUTE: begin
                    r_k <= (r_k == r_filt_len - c_ONE) ? c_ZERO : r_k + c_ONE;
                end
                c_ST_OUT: begin
                    if (psum_ready) r_out_cnt <= r_out_cnt + CW'(1);
                end
                c_ST_ADVANCE: begin
                    r_base <= mod_add(r_base, r_stride);
                end
                default: begin
                end
            endcase
        end
    end

    // Read side decodes from state and registers only.
    assign mac_en     = (r_state == c_ST_COMPUTE);
    assign mac_clr    = mac_en && (r_k == c_ZERO);
    assign if_raddr   = mac_en ? mod_add(r_base, r_k) : c_ZERO;
    assign filt_raddr = mac_en ? r_k : c_ZERO;
    assign psum_valid = (r_state == c_ST_OUT);
    assign filt_ready = (r_state == c_ST_LOAD_F);
    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);
    assign if_full    = w_if_full;
    assign if_count   = r_if_count;
    assign if_waddr   = r_if_wptr;
    assign filt_waddr = r_filt_wptr;
    assign cfg_err    = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_pe_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_row_sequencer
// Purpose  : Self-checking bench for pe_row_sequencer. Expected MAC read
//            pairs and psums are queued as jobs are issued; a monitor pops
//            and compares them whenever the DUT presents mac_en / psum_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_row_sequencer;

    localparam int SIZE = 17;
    localparam int AW   = 5;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] cfg_filt_len;
    logic [AW-1:0] cfg_stride;
    logic [CW-1:0] cfg_num_out;
    logic          filt_wen;
    logic          filt_ready;
    logic [AW-1:0] filt_waddr;
    logic [AW-1:0] filt_raddr;
    logic          if_wen;
    logic          if_full;
    logic [AW-1:0] if_waddr;
    logic [AW-1:0] if_raddr;
    logic [AW-1:0] if_count;
    logic          mac_en;
    logic          mac_clr;
    logic          psum_valid;
    logic          psum_ready;
    logic          busy;
    logic          done;
    logic          cfg_err;

    typedef struct packed {
        logic [AW-1:0] ia;
        logic [AW-1:0] fa;
        logic          clr;
    } pair_t;

    pair_t exp_q[$];
    int    exp_psum_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    clr_cyc  = 0;
    int    hs_cyc   = 0;
    int    tb_base  = 0;
    bit    mon_en   = 1'b0;

    pe_row_sequencer #(.SIZE(SIZE), .AW(AW), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_filt_len (cfg_filt_len),
        .cfg_stride   (cfg_stride),
        .cfg_num_out  (cfg_num_out),
        .filt_wen     (filt_wen),
        .filt_ready   (filt_ready),
        .filt_waddr   (filt_waddr),
        .filt_raddr   (filt_raddr),
        .if_wen       (if_wen),
        .if_full      (if_full),
        .if_waddr     (if_waddr),
        .if_raddr     (if_raddr),
        .if_count     (if_count),
        .mac_en       (mac_en),
        .mac_clr      (mac_clr),
        .psum_valid   (psum_valid),
        .psum_ready   (psum_ready),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented read pair and every new psum.
    initial begin : monitor
        pair_t e;
        int    f;
        bit    prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mac_en) begin
                    if (exp_q.size() == 0) begin
                        chk("mac_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("if_raddr", int'(if_raddr), int'(e.ia));
                        chk("filt_raddr", int'(filt_raddr), int'(e.fa));
                        chk("mac_clr", int'(mac_clr), int'(e.clr));
                    end
                    if (mac_clr) clr_cyc = cyc;
                end
                if (psum_valid && !prev_valid) begin
                    if (exp_psum_q.size() == 0) begin
                        chk("psum_unexpected", 1, 0);
                    end else begin
                        f = exp_psum_q.pop_front();
                        chk("psum_latency", cyc - clr_cyc, f + 1);
                    end
                end
                if (psum_valid && psum_ready) hs_cyc = cyc;
                prev_valid = psum_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_if(input int n);
        for (int i = 0; i < n; i++) begin
            if_wen = 1'b1;
            tick();
        end
        if_wen = 1'b0;
    endtask

    task automatic do_start(input int f, input int s, input int n);
        cfg_filt_len = AW'(f);
        cfg_stride   = AW'(s);
        cfg_num_out  = CW'(n);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic load_filter(input int f);
        for (int i = 0; i < f; i++) begin
            filt_wen = 1'b1;
            chk("filt_ready", int'(filt_ready), 1);
            chk("filt_waddr", int'(filt_waddr), i);
            tick();
        end
        filt_wen = 1'b0;
    endtask

    // Hand-computed window addresses from the bench's own base tracker.
    task automatic push_run(input int f, input int s, input int n);
        pair_t p;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < f; k++) begin
                p.ia  = AW'((tb_base + k) % SIZE);
                p.fa  = AW'(k);
                p.clr = (k == 0);
                exp_q.push_back(p);
            end
            exp_psum_q.push_back(f);
            tb_base = (tb_base + s) % SIZE;
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("done_seen", int'(seen), 1);
        if (seen) begin
            chk("done_latency", cyc - hs_cyc, 2);
            tick();
            chk("done_pulse", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
        end
    endtask

    initial begin : stim
        pair_t p;
        bit    seen;
        rst = 1'b0; start = 1'b0; cfg_filt_len = '0; cfg_stride = '0;
        cfg_num_out = '0; filt_wen = 1'b0; if_wen = 1'b0; psum_ready = 1'b1;
        repeat (2) tick();

        // Reset state
        chk("rst_if_count", int'(if_count), 0);
        chk("rst_if_full", int'(if_full), 0);
        chk("rst_filt_ready", int'(filt_ready), 0);
        chk("rst_mac_en", int'(mac_en), 0);
        chk("rst_mac_clr", int'(mac_clr), 0);
        chk("rst_psum_valid", int'(psum_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_addr", int'(if_waddr) + int'(if_raddr) + int'(filt_waddr) + int'(filt_raddr), 0);
        rst = 1'b1;
        mon_en = 1'b1;

        // Illegal configurations
        do_start(0, 1, 1);
        chk("cfg_err_f0", int'(cfg_err), 1);
        chk("busy_f0", int'(busy), 0);
        tick();
        chk("cfg_err_f0_pulse", int'(cfg_err), 0);
        do_start(3, 4, 1);
        chk("cfg_err_s_gt_f", int'(cfg_err), 1);
        chk("busy_s_gt_f", int'(busy), 0);
        tick();
        chk("cfg_err_s_gt_f_pulse", int'(cfg_err), 0);
        chk("busy_s_gt_f_after", int'(busy), 0);

        // Basic run F=3 S=1 N=4 over six words
        write_if(6);
        chk("basic_if_count", int'(if_count), 6);
        chk("basic_if_waddr", int'(if_waddr), 6);
        push_run(3, 1, 4);
        do_start(3, 1, 4);
        chk("basic_busy", int'(busy), 1);
        load_filter(3);
        wait_done();
        chk("basic_final_count", int'(if_count), 2);

        // Advance base 4 -> 15 with a single wide window
        write_if(9);
        push_run(11, 11, 1);
        do_start(11, 11, 1);
        load_filter(11);
        wait_done();
        chk("wide_final_count", int'(if_count), 0);

        // Wrap: base 15, F=4 -> reads 15,16,0,1
        write_if(4);
        chk("wrap_if_waddr", int'(if_waddr), 2);
        chk("wrap_if_count", int'(if_count), 4);
        push_run(4, 1, 1);
        do_start(4, 1, 1);
        load_filter(4);
        wait_done();
        chk("wrap_final_count", int'(if_count), 3);

        // Backpressure and write coinciding with ADVANCE (S=2)
        write_if(2);
        chk("bp_if_count", int'(if_count), 5);
        psum_ready = 1'b0;
        push_run(2, 2, 1);
        do_start(2, 2, 1);
        load_filter(2);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (psum_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("bp_psum_seen", int'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_psum_hold", int'(psum_valid), 1);
            chk("bp_no_mac", int'(mac_en), 0);
            tick();
        end
        psum_ready = 1'b1;
        tick();
        chk("bp_adv_count", int'(if_count), 5);
        chk("bp_adv_valid", int'(psum_valid), 0);
        if_wen = 1'b1;
        tick();
        if_wen = 1'b0;
        chk("bp_count_after_adv", int'(if_count), 4);
        chk("bp_done", int'(done), 1);
        chk("bp_if_waddr", int'(if_waddr), 5);
        tick();
        chk("bp_idle", int'(busy), 0);

        // Reset mid-COMPUTE at k=1 (base 1)
        p.ia = AW'(1); p.fa = AW'(0); p.clr = 1'b1; exp_q.push_back(p);
        p.ia = AW'(2); p.fa = AW'(1); p.clr = 1'b0; exp_q.push_back(p);
        do_start(3, 1, 1);
        load_filter(3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mac_en && filt_raddr == AW'(1)) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("rst_mid_reach_k1", int'(seen), 1);
        rst = 1'b0;
        tick();
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_mac_en", int'(mac_en), 0);
        chk("rst_mid_if_count", int'(if_count), 0);
        chk("rst_mid_psum_valid", int'(psum_valid), 0);
        rst = 1'b1;
        tb_base = 0;
        repeat (8) tick();
        chk("rst_mid_psum_quiet", int'(psum_valid), 0);

        // Full boundary: 17 writes, last one dropped
        write_if(17);
        chk("full_if_count", int'(if_count), 16);
        chk("full_if_full", int'(if_full), 1);
        chk("full_if_waddr", int'(if_waddr), 16);

        repeat (3) tick();
        chk("pairs_left", exp_q.size(), 0);
        chk("psums_left", exp_psum_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
